// File: rtl/cdc_pkg.sv
// Shared constants and types for the I2S-to-DSP packet crossing.
package cdc_pkg;

    localparam int unsigned DEFAULT_PKT_WIDTH   = 16;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;
    // Wide enough to count up to the deepest legal synchronizer (4).
    localparam int unsigned FILL_CNT_W          = 3;

    typedef logic [DEFAULT_PKT_WIDTH-1:0] pkt_t;

endpackage

// File: rtl/cdc_slow_to_fast_if.sv
// Packet bus from the I2S bit-clock domain into the DSP domain.
interface cdc_slow_to_fast_if
    import cdc_pkg::*;
#(
    parameter int unsigned PKT_WIDTH = DEFAULT_PKT_WIDTH
);

    logic [PKT_WIDTH-1:0] pktI2S_i;
    logic                 pktValidI2S_i;
    logic [PKT_WIDTH-1:0] pktDSP_reg_o;
    logic                 pktChangedDSP_comb_o;

    modport master (
        output pktI2S_i,
        output pktValidI2S_i,
        input  pktDSP_reg_o,
        input  pktChangedDSP_comb_o
    );

    modport slave (
        input  pktI2S_i,
        input  pktValidI2S_i,
        output pktDSP_reg_o,
        output pktChangedDSP_comb_o
    );

endinterface

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-high reset.
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic data_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], data_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_slow_to_fast.sv
// Captures I2S-domain packets into the DSP domain using a synchronized valid strobe;
// the packet bus itself is sampled directly on the synchronized rising edge.
module cdc_slow_to_fast
    import cdc_pkg::*;
#(
    parameter int unsigned PKT_WIDTH   = DEFAULT_PKT_WIDTH,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic               clkDSP_i,
    input  logic               rstDSP_i,
    cdc_slow_to_fast_if.slave  bus
);

    logic                  syncValid;
    logic                  validDly_q;
    logic                  validDly2_q;
    logic                  armed_q,   armed_d;
    logic [FILL_CNT_W-1:0] fillCnt_q, fillCnt_d;
    logic [PKT_WIDTH-1:0]  pkt_q,     pkt_d;
    logic                  filled;
    logic                  loadEn;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_validSync (
        .clk_i  (clkDSP_i),
        .rst_i  (rstDSP_i),
        .data_i (bus.pktValidI2S_i),
        .sync_o (syncValid)
    );

    // The final stage only reflects real input once the chain has refilled after
    // reset; arming waits for a genuine low sample so a held-high valid is not an edge.
    always_comb begin
        filled    = (fillCnt_q == FILL_CNT_W'(SYNC_STAGES));
        fillCnt_d = filled ? fillCnt_q : fillCnt_q + 1'b1;
        armed_d   = armed_q | (filled & ~syncValid);
        loadEn    = syncValid & ~validDly_q & armed_q;
        pkt_d     = loadEn ? bus.pktI2S_i : pkt_q;
    end

    always_ff @(posedge clkDSP_i or posedge rstDSP_i) begin
        if (rstDSP_i) begin
            validDly_q  <= 1'b0;
            validDly2_q <= 1'b0;
            armed_q     <= 1'b0;
            fillCnt_q   <= '0;
            pkt_q       <= '0;
        end else begin
            validDly_q  <= syncValid;
            validDly2_q <= validDly_q;
            armed_q     <= armed_d;
            fillCnt_q   <= fillCnt_d;
            pkt_q       <= pkt_d;
        end
    end

    // A validDly_q rise while armed can only follow a load, so this marks the
    // cycle right after pkt_q updates.
    assign bus.pktChangedDSP_comb_o = validDly_q & ~validDly2_q & armed_q;
    assign bus.pktDSP_reg_o         = pkt_q;

endmodule

// File: tb/tb_cdc_slow_to_fast.sv
// Directed bench for cdc_slow_to_fast: reset, back-to-back delivery, X tolerance,
// repeated values, reset abort, held valid and a 100-packet scoreboard run.
module tb_cdc_slow_to_fast;
    import cdc_pkg::*;

    localparam int HALF_DSP = 83;
    localparam int I2S_PER  = 709;

    logic clkDSP = 1'b0;
    logic rstDSP = 1'b1;

    int   nAsserts = 0;
    int   nFails   = 0;
    int   sentCnt  = 0;
    int   rxCnt    = 0;
    pkt_t lastPkt  = '0;
    pkt_t expQ[$];

    cdc_slow_to_fast_if #(.PKT_WIDTH(16)) bus ();

    cdc_slow_to_fast #(
        .PKT_WIDTH   (16),
        .SYNC_STAGES (2)
    ) dut (
        .clkDSP_i (clkDSP),
        .rstDSP_i (rstDSP),
        .bus      (bus.slave)
    );

    always #HALF_DSP clkDSP = ~clkDSP;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every pulse must deliver the next expected packet.
    always @(negedge clkDSP) begin
        if (!rstDSP && bus.pktChangedDSP_comb_o === 1'b1) begin
            rxCnt++;
            if (expQ.size() == 0) begin
                chk("sb_unexpected_pulse", 32'(bus.pktDSP_reg_o), 32'hFFFF_FFFF);
            end else begin
                chk("sb_order", 32'(bus.pktDSP_reg_o), 32'(expQ.pop_front()));
            end
        end
    end

    // Valid rises mid-cycle, stays high `hold` DSP periods, then low 4 periods with X data.
    task automatic sendPkt(input pkt_t v, input int hold);
        @(negedge clkDSP);
        bus.pktI2S_i      = v;
        bus.pktValidI2S_i = 1'b1;
        expQ.push_back(v);
        sentCnt++;
        @(posedge clkDSP);
        @(posedge clkDSP); #1;
        chk("pre_load_hold", 32'(bus.pktDSP_reg_o), 32'(lastPkt));
        chk("pre_load_pulse", 32'(bus.pktChangedDSP_comb_o), 32'd0);
        @(posedge clkDSP); #1;
        chk("load_value", 32'(bus.pktDSP_reg_o), 32'(v));
        chk("load_pulse", 32'(bus.pktChangedDSP_comb_o), 32'd1);
        @(posedge clkDSP); #1;
        chk("pulse_end", 32'(bus.pktChangedDSP_comb_o), 32'd0);
        for (int i = 0; i < hold - 4; i++) begin
            @(posedge clkDSP); #1;
            chk("held_valid_pulse", 32'(bus.pktChangedDSP_comb_o), 32'd0);
        end
        @(negedge clkDSP);
        bus.pktValidI2S_i = 1'b0;
        bus.pktI2S_i      = 'x;
        for (int i = 0; i < 3; i++) begin
            @(negedge clkDSP);
            chk("low_hold_value", 32'(bus.pktDSP_reg_o), 32'(v));
        end
        lastPkt = v;
    endtask

    initial begin
        bus.pktI2S_i      = '0;
        bus.pktValidI2S_i = 1'b0;

        // Reset for 10 I2S periods, then 30 quiet cycles.
        #10;
        chk("rst_pkt", 32'(bus.pktDSP_reg_o), 32'h0);
        chk("rst_pulse", 32'(bus.pktChangedDSP_comb_o), 32'd0);
        #(10 * I2S_PER);
        chk("rst_pkt_late", 32'(bus.pktDSP_reg_o), 32'h0);
        @(negedge clkDSP);
        rstDSP = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clkDSP); #1;
            chk("idle_pulse", 32'(bus.pktChangedDSP_comb_o), 32'd0);
            chk("idle_pkt", 32'(bus.pktDSP_reg_o), 32'h0);
        end

        // Walking-one packets back-to-back, X on the data bus while valid is low.
        sendPkt(16'h0001, 4);
        sendPkt(16'h0010, 4);
        sendPkt(16'h0100, 4);
        sendPkt(16'h1000, 4);
        chk("four_pulses", 32'(rxCnt), 32'd4);

        // Same value twice still pulses twice.
        sendPkt(16'hAAAA, 4);
        sendPkt(16'hAAAA, 4);
        chk("repeat_pulses", 32'(rxCnt), 32'd6);
        chk("repeat_value", 32'(bus.pktDSP_reg_o), 32'hAAAA);

        // Valid held high for 12 cycles loads once.
        sendPkt(16'hDDDD, 12);
        chk("held_one_load", 32'(rxCnt), 32'd7);

        // Reset one DSP cycle after valid rises aborts the transfer.
        @(negedge clkDSP);
        bus.pktI2S_i      = 16'hBBBB;
        bus.pktValidI2S_i = 1'b1;
        @(negedge clkDSP);
        rstDSP = 1'b1;
        #1;
        chk("abort_pkt_rst", 32'(bus.pktDSP_reg_o), 32'h0);
        chk("abort_pulse_rst", 32'(bus.pktChangedDSP_comb_o), 32'd0);
        @(negedge clkDSP);
        @(negedge clkDSP);
        rstDSP = 1'b0;
        @(negedge clkDSP);
        bus.pktValidI2S_i = 1'b0;
        bus.pktI2S_i      = 'x;
        for (int i = 0; i < 8; i++) begin
            @(posedge clkDSP); #1;
            chk("abort_no_pulse", 32'(bus.pktChangedDSP_comb_o), 32'd0);
            chk("abort_pkt", 32'(bus.pktDSP_reg_o), 32'h0);
        end
        chk("abort_rx_count", 32'(rxCnt), 32'd7);
        lastPkt = '0;
        sendPkt(16'hCCCC, 4);
        chk("after_abort_rx", 32'(rxCnt), 32'd8);

        // 100 distinct packets through the scoreboard.
        rxCnt   = 0;
        sentCnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (i < 10) begin
                sendPkt(16'hAAA0 + 16'(i), 4);
            end else begin
                sendPkt(16'h1000 + 16'(i), 4);
            end
        end
        repeat (4) @(posedge clkDSP);
        #1;
        chk("sb_sent", 32'(sentCnt), 32'd100);
        chk("sb_received", 32'(rxCnt), 32'd100);
        chk("sb_queue_empty", 32'(expQ.size()), 32'd0);
        chk("final_value", 32'(bus.pktDSP_reg_o), 32'h1063);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
